// File: rtl/strawberry_pkg.sv
// Shared constants for the strawberry core pipeline-control blocks.
// Retrigger policies select how a new stall request merges with one already counting.
package strawberry_pkg;

   localparam int MODE_MAX     = 0;
   localparam int MODE_RESTART = 1;
   localparam int MODE_ADD_SAT = 2;

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector: registers the input and flags 0->1 transitions.
// The register clears on reset, so a level held through reset reads as a rise on release.
module rise_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in,
   output logic [W-1:0] rise
);

   logic [W-1:0] in_q;
   logic [W-1:0] in_d;

   always_comb begin
      in_d = in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q <= '0;
      end else begin
         in_q <= in_d;
      end
   end

   assign rise = in & ~in_q;

endmodule

// File: rtl/stall_timer.sv
// Programmable PC-stall generator: holds pcEn low for the merged delay of rising requests.
// Idle/stall is implied by count_q (zero or not); there is no separate state register.
module stall_timer
   import strawberry_pkg::*;
#(
   parameter int CNT_W = 3,
   parameter int N_REQ = 4,
   parameter int MODE  = MODE_MAX
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] req_delay,
   input  logic                   flush,
   output logic                   pcEn,
   output logic                   busy,
   output logic [CNT_W-1:0]       remaining,
   output logic                   done
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_REQ-1:0]            trig;
   logic [N_REQ-1:0][CNT_W-1:0] cand;
   logic [CNT_W-1:0]            load;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             done_q;
   logic             done_d;

   logic [CNT_W-1:0] dec;
   logic [CNT_W:0]   sum;

   rise_detect #(
      .W (N_REQ)
   ) u_rise (
      .clk  (clk),
      .rst  (rst),
      .in   (req),
      .rise (trig)
   );

   // Non-triggering requesters contribute zero so they never win the max.
   for (genvar i = 0; i < N_REQ; i++) begin : g_cand
      assign cand[i] = trig[i] ? req_delay[i*CNT_W +: CNT_W] : '0;
   end

   always_comb begin
      load = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (cand[i] > load) begin
            load = cand[i];
         end
      end
   end

   always_comb begin
      dec = count_q - 1'b1;
      sum = {1'b0, dec} + {1'b0, load};
   end

   always_comb begin
      count_d = count_q;
      done_d  = 1'b0;
      if (flush) begin
         count_d = '0;
      end else if (count_q == '0) begin
         if (load != '0) begin
            count_d = load;
         end
      end else if (load == '0) begin
         count_d = dec;
         done_d  = (dec == '0);
      end else begin
         // Retrigger with a nonzero load always leaves the count nonzero, so no done.
         if (MODE == MODE_RESTART) begin
            count_d = load;
         end else if (MODE == MODE_ADD_SAT) begin
            count_d = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
         end else begin
            count_d = (dec > load) ? dec : load;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign pcEn      = (count_q == '0);
   assign busy      = ~pcEn;
   assign remaining = count_q;
   assign done      = done_q;

endmodule

// File: tb/tb_stall_timer.sv
// Directed and randomized checks of stall_timer, one instance per retrigger mode.
// All three instances share stimulus; expected values come from hand tables and a small model.
module tb_stall_timer;
   import strawberry_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [3:0]  req = '0;
   logic [11:0] req_delay = '0;

   logic        pc_en [3];
   logic        busy  [3];
   logic        done  [3];
   logic [2:0]  rem   [3];

   int n_chk = 0;
   int n_err = 0;

   int          m_cnt  [3];
   logic        m_done [3];
   logic [3:0]  m_prev;

   stall_timer #(.CNT_W(3), .N_REQ(4), .MODE(MODE_MAX)) u_max (
      .clk(clk), .rst(rst), .req(req), .req_delay(req_delay), .flush(flush),
      .pcEn(pc_en[0]), .busy(busy[0]), .remaining(rem[0]), .done(done[0]));

   stall_timer #(.CNT_W(3), .N_REQ(4), .MODE(MODE_RESTART)) u_rst (
      .clk(clk), .rst(rst), .req(req), .req_delay(req_delay), .flush(flush),
      .pcEn(pc_en[1]), .busy(busy[1]), .remaining(rem[1]), .done(done[1]));

   stall_timer #(.CNT_W(3), .N_REQ(4), .MODE(MODE_ADD_SAT)) u_add (
      .clk(clk), .rst(rst), .req(req), .req_delay(req_delay), .flush(flush),
      .pcEn(pc_en[2]), .busy(busy[2]), .remaining(rem[2]), .done(done[2]));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_dly(input int i, input int v);
      logic [2:0] d;
      d = v[2:0];
      req_delay[i*3 +: 3] = d;
   endtask

   task automatic chk_dut(input int u, input string tag, input int er, input int ed);
      chk($sformatf("%s.m%0d.rem", tag, u), 32'(rem[u]), er);
      chk($sformatf("%s.m%0d.pcEn", tag, u), 32'(pc_en[u]), (er == 0) ? 1 : 0);
      chk($sformatf("%s.m%0d.busy", tag, u), 32'(busy[u]), (er == 0) ? 0 : 1);
      chk($sformatf("%s.m%0d.done", tag, u), 32'(done[u]), ed);
   endtask

   task automatic chk_all(input string tag, input int er, input int ed);
      for (int u = 0; u < 3; u++) chk_dut(u, tag, er, ed);
   endtask

   initial begin
      // Reset with all requests high; the stall starts on the first edge after release.
      req = 4'hF;
      set_dly(0, 3); set_dly(1, 2); set_dly(2, 5); set_dly(3, 6);
      step; step;
      chk_all("reset", 0, 0);
      rst = 1'b0;
      step;
      chk_all("rst_rel", 6, 0);
      for (int k = 5; k >= 1; k--) begin
         step; chk_all($sformatf("rst_cnt%0d", k), k, 0);
      end
      step; chk_all("rst_done", 0, 1);

      // Single request, delay 3, then held high.
      req = 4'h0; step; chk_all("idle", 0, 0);
      req = 4'h1;
      step; chk_all("single3", 3, 0);
      step; chk_all("single2", 2, 0);
      step; chk_all("single1", 1, 0);
      step; chk_all("single_done", 0, 1);
      step; chk_all("single_hold", 0, 0);

      // Merge of delays 2 and 5; then a lone zero-delay request.
      req = 4'h0; step;
      req = 4'b0110;
      step; chk_all("merge5", 5, 0);
      for (int k = 4; k >= 1; k--) begin
         step; chk_all($sformatf("merge%0d", k), k, 0);
      end
      step; chk_all("merge_done", 0, 1);
      req = 4'h0; step;
      set_dly(3, 0); req = 4'b1000;
      step; chk_all("zero_dly", 0, 0);
      step; chk_all("zero_dly2", 0, 0);

      // Retrigger at remaining=2 with load 4.
      req = 4'h0; step;
      set_dly(0, 5); req = 4'h1;
      step; chk_all("pre5", 5, 0);
      step; step; step; chk_all("pre2", 2, 0);
      set_dly(1, 4); req = 4'h3;
      step;
      chk_dut(0, "retrig_max", 4, 0);
      chk_dut(1, "retrig_restart", 4, 0);
      chk_dut(2, "retrig_add", 5, 0);
      flush = 1'b1;
      step; chk_all("flush_clr", 0, 0);
      flush = 1'b0; req = 4'h0;
      step; chk_all("flush_idle", 0, 0);

      // Retrigger at remaining=2 with load 7: ADD_SAT saturates at 7.
      req = 4'h1;
      step; step; step; step; chk_all("sat_pre2", 2, 0);
      set_dly(2, 7); req = 4'b0101;
      step; chk_all("sat7", 7, 0);

      // Flush at remaining=3 beats a simultaneous trigger.
      step; step; step; step; chk_all("fl_pre3", 3, 0);
      flush = 1'b1; set_dly(3, 6); req = 4'b1101;
      step; chk_all("flush_trig", 0, 0);
      flush = 1'b0;
      step; chk_all("flush_norestart", 0, 0);
      step; chk_all("flush_norestart2", 0, 0);

      // Asynchronous reset between edges mid-stall.
      req = 4'h0; step;
      set_dly(0, 5); req = 4'h1;
      step; chk_all("async_pre5", 5, 0);
      step; chk_all("async_pre4", 4, 0);
      #2 rst = 1'b1;
      #1 chk_all("async_rst", 0, 0);
      req = 4'h0;
      step;
      rst = 1'b0;
      step; chk_all("async_rel", 0, 0);

      // Random regression against a behavioural model of all three modes.
      for (int u = 0; u < 3; u++) begin
         m_cnt[u] = 0;
         m_done[u] = 1'b0;
      end
      m_prev = 4'h0;
      for (int n = 0; n < 400; n++) begin
         int ld;
         int dlv;
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         req_delay = 12'($urandom);
         flush = ($urandom_range(0, 15) == 0);
         ld = 0;
         for (int i = 0; i < 4; i++) begin
            dlv = int'(req_delay[i*3 +: 3]);
            if (req[i] && !m_prev[i] && dlv > ld) ld = dlv;
         end
         for (int u = 0; u < 3; u++) begin
            int dec;
            if (flush) begin
               m_cnt[u] = 0; m_done[u] = 1'b0;
            end else if (m_cnt[u] == 0) begin
               m_cnt[u] = ld; m_done[u] = 1'b0;
            end else begin
               dec = m_cnt[u] - 1;
               m_done[u] = 1'b0;
               if (ld == 0) begin
                  m_cnt[u] = dec; m_done[u] = (dec == 0);
               end else if (u == 0) begin
                  m_cnt[u] = (dec > ld) ? dec : ld;
               end else if (u == 1) begin
                  m_cnt[u] = ld;
               end else begin
                  m_cnt[u] = (dec + ld > 7) ? 7 : dec + ld;
               end
            end
         end
         m_prev = req;
         step;
         for (int u = 0; u < 3; u++) chk_dut(u, $sformatf("rand%0d", n), m_cnt[u], m_done[u]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
